// File: rtl/fib_pkg.sv
// Shared types and seed values for the additive-recurrence sequence engine.
// The seeds are narrow constants that the top zero-extends to its WIDTH.
package fib_pkg;

  typedef enum logic [1:0] {
    FIB   = 2'd0,
    LUCAS = 2'd1,
    TRIB  = 2'd2,
    RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEED_B = 2'd1;
  localparam logic [1:0] SEED_C = 2'd2;

  // Lucas is the only recurrence whose first term is 2; the reserved mode falls back to Fibonacci.
  function automatic logic [1:0] seed_a(mode_e m);
    return (m == LUCAS) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fib_step_add.sv
// Combinational 2/3-operand term adder with sticky overflow propagation.
// Latency 0 (pure combinational); no handshake, so no backpressure.
// Overflow is any adder carry-out, ORed with the flags of the operands in use.
module fib_step_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             ox,
  input  logic             oy,
  input  logic             oz,
  input  logic             three_op,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH+1:0] full;
  logic [WIDTH+1:0] z_ext;

  always_comb begin
    z_ext = three_op ? {2'b00, z} : '0;
    full  = {2'b00, x} + {2'b00, y} + z_ext;
    sum   = full[WIDTH-1:0];
    ovf   = (|full[WIDTH+1:WIDTH]) | ox | oy | (three_op & oz);
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Computes term n of Fibonacci/Lucas/Tribonacci over a four-phase req/fin handshake.
// Latency n+1 cycles after the accepting edge; FIB_SATURATE_EN enables early saturating exit on overflow.
// Dropping req mid-run aborts; fin holds until req drops, and no new request is taken until fin is low.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] n,
  input  logic [1:0]       mode,
  output logic             fin,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             err
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             oa_q, oa_d, ob_q, ob_d, oc_q, oc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             trib;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             sat_hit;

  assign trib = (mode_q == TRIB);

`ifdef FIB_SATURATE_EN
  // Only the current term's flag exits early; lookahead flags wait until they shift into a.
  assign sat_hit = oa_q;
`else
  assign sat_hit = 1'b0;
`endif

  fib_step_add #(.WIDTH(WIDTH)) u_add (
    .x        (a_q),
    .y        (b_q),
    .z        (c_q),
    .ox       (oa_q),
    .oy       (ob_q),
    .oz       (oc_q),
    .three_op (trib),
    .sum      (sum),
    .ovf      (sum_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= FIB;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      oa_q     <= 1'b0;
      ob_q     <= 1'b0;
      oc_q     <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      oa_q     <= oa_d;
      ob_q     <= ob_d;
      oc_q     <= oc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = RUN;
      RUN: begin
        if (!req) state_d = IDLE;
        else if (cnt_q == '0 || sat_hit) state_d = DONE;
      end
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    oa_d     = oa_q;
    ob_d     = ob_q;
    oc_d     = oc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          mode_d = mode_e'(mode);
          cnt_d  = n;
          a_d    = WIDTH'(seed_a(mode_e'(mode)));
          b_d    = WIDTH'(SEED_B);
          c_d    = WIDTH'(SEED_C);
          oa_d   = 1'b0;
          ob_d   = 1'b0;
          oc_d   = 1'b0;
          err_d  = (mode_e'(mode) == RSVD);
        end
      end
      RUN: begin
        if (req) begin
          if (cnt_q == '0 || sat_hit) begin
            result_d = sat_hit ? '1 : a_q;
            ovf_d    = oa_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
            a_d   = b_q;
            oa_d  = ob_q;
            if (trib) begin
              b_d  = c_q;
              ob_d = oc_q;
              c_d  = sum;
              oc_d = sum_ovf;
            end else begin
              b_d  = sum;
              ob_d = sum_ovf;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    fin    = (state_q == DONE);
    result = result_q;
    ovf    = ovf_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: latency, values, overflow, abort, async reset, back-to-back.
// Expectations are hand-computed; FIB_SATURATE_EN switches the n=47 overflow expectations.
module tb_fib_seq_gen;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] n;
  logic [1:0]  mode;
  logic        fin;
  logic        busy;
  logic [31:0] result;
  logic        ovf;
  logic        err;

  int checks;
  int failures;

  fib_seq_gen #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .n      (n),
    .mode   (mode),
    .fin    (fin),
    .busy   (busy),
    .result (result),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; raises req, waits for the accepting edge, then counts edges until fin.
  task automatic run_req(input logic [31:0] nn, input logic [1:0] mm, output int cyc, output bit to);
    req  = 1'b1;
    n    = nn;
    mode = mm;
    @(posedge clk);
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (fin) begin
        to = 1'b0;
        break;
      end
    end
    n    = $urandom;
    mode = 2'($urandom_range(3));
  endtask

  task automatic drop_req;
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_done(input string name, input bit to, input int cyc, input int exp_cyc,
                             input logic [31:0] exp_res, input logic exp_ovf, input logic exp_err);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s timeout: fin never rose within 200 cycles", name);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (result !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %0d, expected %0d", name, result, exp_res);
    end
    checks++;
    if (ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s ovf: got %b, expected %b", name, ovf, exp_ovf);
    end
    checks++;
    if (err !== exp_err) begin
      failures++;
      $display("FAIL %s err: got %b, expected %b", name, err, exp_err);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({fin, busy, ovf, err} !== 4'b0000 || result !== 32'd0) begin
      failures++;
      $display("FAIL %s: fin=%b busy=%b ovf=%b err=%b result=%0d, expected all 0",
               name, fin, busy, ovf, err, result);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    n     = '0;
    mode  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    while ($time < 100) @(negedge clk);
  endtask

  task automatic test_fibonacci;
    int cyc;
    bit to;
    run_req(32'd44, 2'd0, cyc, to);
    expect_done("fib44", to, cyc, 45, 32'd1134903170, 1'b0, 1'b0);
    drop_req();
    checks++;
    if (fin !== 1'b0) begin
      failures++;
      $display("FAIL fib44_fin_drop: fin=%b one cycle after req drop, expected 0", fin);
    end
    run_req(32'd46, 2'd0, cyc, to);
    expect_done("fib46", to, cyc, 47, 32'd2971215073, 1'b0, 1'b0);
    drop_req();
  endtask

  task automatic test_overflow;
    int cyc;
    bit to;
    run_req(32'd47, 2'd0, cyc, to);
`ifdef FIB_SATURATE_EN
    expect_done("fib47_sat", to, cyc, 48, 32'hFFFF_FFFF, 1'b1, 1'b0);
`else
    expect_done("fib47", to, cyc, 48, 32'd512559680, 1'b1, 1'b0);
`endif
    drop_req();
  endtask

  task automatic test_lucas_trib;
    int cyc;
    bit to;
    run_req(32'd0, 2'd1, cyc, to);
    expect_done("lucas0", to, cyc, 1, 32'd2, 1'b0, 1'b0);
    drop_req();
    run_req(32'd10, 2'd1, cyc, to);
    expect_done("lucas10", to, cyc, 11, 32'd123, 1'b0, 1'b0);
    drop_req();
    run_req(32'd5, 2'd2, cyc, to);
    expect_done("trib5", to, cyc, 6, 32'd13, 1'b0, 1'b0);
    drop_req();
    run_req(32'd5, 2'd3, cyc, to);
    expect_done("rsvd5", to, cyc, 6, 32'd8, 1'b0, 1'b1);
    drop_req();
  endtask

  task automatic test_abort;
    int fin_seen;
    req  = 1'b1;
    n    = 32'd40;
    mode = 2'd0;
    @(posedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before: busy=%b, expected 1", busy);
    end
    drop_req();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_after: busy=%b, expected 0", busy);
    end
    fin_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fin) fin_seen++;
    end
    checks++;
    if (fin_seen !== 0) begin
      failures++;
      $display("FAIL abort_fin: fin high for %0d cycles, expected 0", fin_seen);
    end
    checks++;
    if (result !== 32'd8) begin
      failures++;
      $display("FAIL abort_result: got %0d, expected prior value 8", result);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    bit to;
    req  = 1'b1;
    n    = 32'd40;
    mode = 2'd0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_run");
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(32'd2, 2'd2, cyc, to);
    expect_done("trib2_pre_reset", to, cyc, 3, 32'd2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_in_done");
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(32'd3, 2'd0, cyc, to);
    expect_done("fib3_after_reset", to, cyc, 4, 32'd3, 1'b0, 1'b0);
    drop_req();
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    run_req(32'd47, 2'd3, cyc, to);
`ifdef FIB_SATURATE_EN
    expect_done("b2b_first", to, cyc, 48, 32'hFFFF_FFFF, 1'b1, 1'b1);
`else
    expect_done("b2b_first", to, cyc, 48, 32'd512559680, 1'b1, 1'b1);
`endif
    drop_req();
    run_req(32'd5, 2'd1, cyc, to);
    expect_done("b2b_second", to, cyc, 6, 32'd11, 1'b0, 1'b0);
    drop_req();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fibonacci();
    test_overflow();
    test_lucas_trib();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Clocked, parametrised successor to the fixed Fibonacci block.
- Computes term N of a selectable additive recurrence: Fibonacci, Lucas or Tribonacci.
- Datapath width is configurable; the block reports overflow.
- Talks to the requester over a four-phase req/fin handshake. It is the shared sequence engine for benches and for higher-level controllers.

Parameters:
- WIDTH, 32, bit width of n, result and all internal term registers.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  four-phase request; held high until fin is seen high, then dropped
- n  in  WIDTH  term index, numbered from 0; sampled on the accepting edge
- mode  in  2  0=Fibonacci, 1=Lucas, 2=Tribonacci, 3=reserved; sampled with n
- fin  out  1  result valid; four-phase acknowledge
- busy  out  1  high in RUN
- result  out  WIDTH  term n, modulo 2^WIDTH; held stable while fin=1
- ovf  out  1  true value of term n exceeds 2^WIDTH-1
- err  out  1  mode=3 was sampled

Behaviour:
- Reset (async, rst_n=0): state=IDLE; fin, busy, result, ovf, err all 0; internal term registers and counter all 0. Takes effect immediately, including mid-RUN and in DONE.
- Term definitions:
  - Fibonacci: seeds a=1, b=1; step a<=b, b<=a+b.
  - Lucas: seeds a=2, b=1; same step as Fibonacci.
  - Tribonacci: seeds a=1, b=1, c=2; step a<=b, b<=c, c<=a+b+c.
  - Mode 3: err=1; the block computes Fibonacci.
- States:
  - IDLE: on a clock edge with req=1, load seeds, cnt<=n, latch mode, clear ovf flags, set err. Go to RUN; busy=1.
  - RUN, cnt!=0: one step per cycle; cnt<=cnt-1.
  - RUN, cnt==0: result<=a, ovf<=oa. Go to DONE; fin=1, busy=0.
  - RUN, req=0 sampled: abort. Go to IDLE; fin stays 0; result/ovf/err keep their old values.
  - DONE: fin=1 while req=1. On the first edge with req=0: fin<=0, go to IDLE. result, ovf and err stay held until the next accept.
- Latency: req sampled at edge k, fin high after edge k+n+1. n=0 gives fin after edge k+1.
- Overflow tracking:
  - Each term register has a sticky flag (oa, ob, oc).
  - A newly summed term's flag = OR of its operand flags OR the adder carry-out. Tribonacci uses a 3-operand add with a 2-bit carry; any non-zero carry sets the flag.
  - Shifted terms carry their flag along with them.
  - ovf reflects term n only. Overflow in lookahead terms b/c does not set ovf.
- Handshake:
  - In IDLE, a new req is not accepted until fin has returned low.
  - n and mode are don't-care outside the accepting edge.
  - req must not rise in the same cycle that fin falls. If req is still high in IDLE, the block re-accepts on the next edge.
- Width: cnt is WIDTH bits. Any n is legal; the cycle count grows linearly with n.

Optional Feature:
- Macro: FIB_SATURATE_EN.
- Defined:
  - When oa becomes 1 in RUN, result<=all-ones and ovf<=1, and the block goes to DONE on the next edge (early exit). Total latency is at most the normal latency.
  - Lookahead overflow in b/c must not trigger early exit until that term reaches a.
- Undefined: modulo behaviour as specified above.

Decomposition:
- Package fib_pkg:
  - mode enum: FIB, LUCAS, TRIB, RSVD.
  - State enum: IDLE, RUN, DONE.
  - Seed constants per mode, as functions of WIDTH.
- Sub-module fib_step_add: combinational 2/3-operand adder. It returns the WIDTH-bit sum and an overflow bit that ORs in the operand flags.

Test Plan:
- Fibonacci, WIDTH=32, n=44, req rises at 100 ns: fin after exactly n+1 cycles; result=1134903170, ovf=0, err=0; fin drops one cycle after req drops.
- Fibonacci n=46 → result=2971215073, ovf=0. Fibonacci n=47 → result=512559680, ovf=1; with FIB_SATURATE_EN → result=0xFFFFFFFF, ovf=1, fin no later than cycle 48.
- Lucas n=0 → 2 after 1 cycle; Lucas n=10 → 123. Tribonacci n=5 → 13; mode=3, n=5 → result=8, err=1.
- Drop req mid-RUN (Fibonacci n=40, drop at cycle 10): busy=0 next cycle, fin never rises, result keeps its prior value.
- rst_n pulsed low asynchronously mid-RUN and again in DONE: all outputs 0 immediately. A new request after release (Fibonacci n=3) → result=3.
- Back-to-back requests: second req rises the cycle after fin falls, with a different mode and n; the second result is correct with no stale ovf or err.
